// File: rtl/structs.sv
// Types shared by the CDB arbiter and its snoopers (LSQ, ROB, reservation stations).
package structs_pkg;
    localparam int ROB_W    = 4;
    localparam int RESULT_W = 32;

    typedef struct packed {
        logic [ROB_W-1:0]    dest_ROB_entry;
        logic [RESULT_W-1:0] result;
        logic                load_step1;
    } CDB_packet_t;

    typedef struct packed {
        logic [ROB_W-1:0]    rob;
        logic [RESULT_W-1:0] result;
        logic                load_step1;
    } cdb_entry_t;

    localparam logic [ROB_W-1:0] ROB_NONE = '0;
endpackage

// File: rtl/cdb_arbiter_if.sv
// Producer-side handshake and CDB broadcast bundle for cdb_arbiter.
interface cdb_arbiter_if
    import structs_pkg::*;
#(
    parameter int NUM_SRC = 3
) ();
    logic [NUM_SRC-1:0]               src_valid;
    logic [NUM_SRC-1:0]               src_ready;
    logic [NUM_SRC-1:0][ROB_W-1:0]    src_rob;
    logic [NUM_SRC-1:0][RESULT_W-1:0] src_result;
    logic [NUM_SRC-1:0]               src_load_step1;
    logic                             cdb_valid;
    CDB_packet_t                      cdb_out;

    modport master (
        output src_valid, src_rob, src_result, src_load_step1,
        input  src_ready, cdb_valid, cdb_out
    );

    modport slave (
        input  src_valid, src_rob, src_result, src_load_step1,
        output src_ready, cdb_valid, cdb_out
    );
endinterface

// File: rtl/cdb_src_fifo.sv
// Per-producer result buffer; occupancy count separates full from empty.
module cdb_src_fifo
    import structs_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       flush,
    input  logic       push,
    input  cdb_entry_t push_data,
    input  logic       pop,
    output logic       full,
    output logic       empty,
    output cdb_entry_t head
);
    localparam int PW = $clog2(DEPTH);

    cdb_entry_t    mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin Common Data Bus arbiter with per-source buffers and a registered output.
// Define CDB_ADDR_PRIORITY_EN to favour heads carrying load/store addresses.
module cdb_arbiter
    import structs_pkg::*;
#(
    parameter int NUM_SRC   = 3,
    parameter int BUF_DEPTH = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    cdb_arbiter_if.slave  bus
);
    localparam int SW = $clog2(NUM_SRC);

    logic [NUM_SRC-1:0] full;
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic [NUM_SRC-1:0] head_addr;
    cdb_entry_t         head [NUM_SRC];
    logic [SW-1:0]      rr_ptr;
    logic [SW-1:0]      grant_idx;
    logic               grant_valid;
    logic               cdb_valid_q;
    CDB_packet_t        cdb_out_q;
    cdb_entry_t         win;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        cdb_entry_t push_data;

        // Tag 0 means "no destination": accepted from the producer but never stored.
        assign push[i]      = bus.src_valid[i] && !full[i] && !flush && (bus.src_rob[i] != ROB_NONE);
        assign pop[i]       = grant_valid && (grant_idx == SW'(i)) && !flush;
        assign head_addr[i] = !empty[i] && head[i].load_step1;
        assign push_data    = '{rob: bus.src_rob[i], result: bus.src_result[i],
                                load_step1: bus.src_load_step1[i]};

        cdb_src_fifo #(.DEPTH(BUF_DEPTH)) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .push      (push[i]),
            .push_data (push_data),
            .pop       (pop[i]),
            .full      (full[i]),
            .empty     (empty[i]),
            .head      (head[i])
        );
    end

    assign bus.src_ready = ~full;

    always_comb begin
        logic [NUM_SRC-1:0] cand;
        int                 idx;
        cand        = ~empty;
`ifdef CDB_ADDR_PRIORITY_EN
        if (|head_addr) cand = head_addr;
`endif
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        // Walk backwards so the candidate closest to rr_ptr is the last one written.
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NUM_SRC;
            if (cand[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = SW'(idx);
            end
        end
    end

    assign win = head[grant_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cdb_valid_q <= 1'b0;
            cdb_out_q   <= '0;
            rr_ptr      <= '0;
        end else if (flush) begin
            cdb_valid_q <= 1'b0;
            cdb_out_q   <= '0;
        end else begin
            cdb_valid_q <= grant_valid;
            cdb_out_q   <= grant_valid ? CDB_packet_t'{win.rob, win.result, win.load_step1} : '0;
            if (grant_valid)
                rr_ptr <= (grant_idx == SW'(NUM_SRC - 1)) ? '0 : grant_idx + SW'(1);
        end
    end

    assign bus.cdb_valid = cdb_valid_q;
    assign bus.cdb_out   = cdb_out_q;

    logic unused_head_addr;
    assign unused_head_addr = ^head_addr;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: directed vector table, corner sequences, random vs. queue model.
module tb_cdb_arbiter;
    import structs_pkg::*;

    localparam int NUM_SRC   = 3;
    localparam int BUF_DEPTH = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic flush = 1'b0;

    cdb_arbiter_if #(.NUM_SRC(NUM_SRC)) bus();

    cdb_arbiter #(.NUM_SRC(NUM_SRC), .BUF_DEPTH(BUF_DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one queue per producer, a round-robin start index, the last broadcast.
    CDB_packet_t mq [NUM_SRC][$];
    int          m_rr;
    logic        m_valid;
    CDB_packet_t m_pkt;
    bit          last_acc [NUM_SRC];

    typedef struct packed {
        logic [2:0]  valid;
        logic [11:0] robs;
        logic [2:0]  ls1;
        logic [31:0] res;
        logic        ev;
        CDB_packet_t epkt;
    } vec_t;

    vec_t tbl [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ev, input CDB_packet_t ep, input logic [2:0] er);
        chk({tag, ".valid"}, 64'(bus.cdb_valid), 64'(ev));
        chk({tag, ".pkt"},   64'(bus.cdb_out),   64'(ep));
        chk({tag, ".ready"}, 64'(bus.src_ready), 64'(er));
    endtask

    function automatic vec_t mk(input logic [2:0] v, input logic [3:0] r2, input logic [3:0] r1,
                                input logic [3:0] r0, input logic [2:0] ls, input logic [31:0] res,
                                input logic ev, input logic [3:0] erob, input logic [31:0] eres,
                                input logic els1);
        vec_t t;
        t.valid = v;
        t.robs  = {r2, r1, r0};
        t.ls1   = ls;
        t.res   = res;
        t.ev    = ev;
        t.epkt  = ev ? CDB_packet_t'{erob, eres, els1} : '0;
        return t;
    endfunction

    function automatic int pick(input bit only_addr);
        for (int k = 0; k < NUM_SRC; k++) begin
            int s;
            s = (m_rr + k) % NUM_SRC;
            if (mq[s].size() > 0 && (!only_addr || mq[s][0].load_step1)) return s;
        end
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
        m_rr    = 0;
        m_valid = 1'b0;
        m_pkt   = '0;
    endtask

    task automatic set_src(input int i, input logic v, input logic [3:0] rob,
                           input logic [31:0] res, input logic ls1);
        bus.src_valid[i]      = v;
        bus.src_rob[i]        = rob;
        bus.src_result[i]     = res;
        bus.src_load_step1[i] = ls1;
    endtask

    task automatic idle_all();
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 1'b0, 4'd0, 32'd0, 1'b0);
    endtask

    // Advance one clock: update the model from the presented inputs, then compare after the edge.
    task automatic step(input string tag);
        int         w;
        logic [2:0] er;
        for (int i = 0; i < NUM_SRC; i++)
            last_acc[i] = bus.src_valid[i] && (mq[i].size() < BUF_DEPTH);
        if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) mq[i].delete();
            m_valid = 1'b0;
            m_pkt   = '0;
        end else begin
            w = -1;
`ifdef CDB_ADDR_PRIORITY_EN
            w = pick(1'b1);
`endif
            if (w < 0) w = pick(1'b0);
            if (w >= 0) begin
                m_pkt   = mq[w].pop_front();
                m_valid = 1'b1;
                m_rr    = (w + 1) % NUM_SRC;
            end else begin
                m_valid = 1'b0;
                m_pkt   = '0;
            end
            for (int i = 0; i < NUM_SRC; i++)
                if (last_acc[i] && bus.src_rob[i] != 4'd0)
                    mq[i].push_back(CDB_packet_t'{bus.src_rob[i], bus.src_result[i], bus.src_load_step1[i]});
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_SRC; i++) er[i] = (mq[i].size() < BUF_DEPTH);
        chk_out(tag, m_valid, m_pkt, er);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] got [$];
        bit         saw_stall;
        int         bp_i;
        logic [3:0] bp_tags [3];

        idle_all();
        m_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_out("reset", 1'b0, '0, 3'b111);

        // Directed table: three-way contest, single result, rr realignment, priority, tag-0 discard.
        tbl.push_back(mk(3'b111, 4'd3, 4'd2, 4'd1, 3'b000, 32'd100, 1'b0, 4'd0, 32'd0, 1'b0));
        tbl.push_back(mk(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 32'd0,   1'b1, 4'd1, 32'd100, 1'b0));
        tbl.push_back(mk(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 32'd0,   1'b1, 4'd2, 32'd101, 1'b0));
        tbl.push_back(mk(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 32'd0,   1'b1, 4'd3, 32'd102, 1'b0));
        tbl.push_back(mk(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 32'd0,   1'b0, 4'd0, 32'd0, 1'b0));
        tbl.push_back(mk(3'b001, 4'd0, 4'd0, 4'd5, 3'b000, 32'hDEAD_BEEF, 1'b0, 4'd0, 32'd0, 1'b0));
        tbl.push_back(mk(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 32'd0,   1'b1, 4'd5, 32'hDEAD_BEEF, 1'b0));
        tbl.push_back(mk(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 32'd0,   1'b0, 4'd0, 32'd0, 1'b0));
        tbl.push_back(mk(3'b100, 4'd9, 4'd0, 4'd0, 3'b000, 32'd200, 1'b0, 4'd0, 32'd0, 1'b0));
        tbl.push_back(mk(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 32'd0,   1'b1, 4'd9, 32'd202, 1'b0));
        tbl.push_back(mk(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 32'd0,   1'b0, 4'd0, 32'd0, 1'b0));
        tbl.push_back(mk(3'b011, 4'd0, 4'd3, 4'd2, 3'b010, 32'd300, 1'b0, 4'd0, 32'd0, 1'b0));
`ifdef CDB_ADDR_PRIORITY_EN
        tbl.push_back(mk(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 32'd0,   1'b1, 4'd3, 32'd301, 1'b1));
        tbl.push_back(mk(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 32'd0,   1'b1, 4'd2, 32'd300, 1'b0));
`else
        tbl.push_back(mk(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 32'd0,   1'b1, 4'd2, 32'd300, 1'b0));
        tbl.push_back(mk(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 32'd0,   1'b1, 4'd3, 32'd301, 1'b1));
`endif
        tbl.push_back(mk(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 32'd0,   1'b0, 4'd0, 32'd0, 1'b0));
        tbl.push_back(mk(3'b001, 4'd0, 4'd0, 4'd0, 3'b000, 32'd400, 1'b0, 4'd0, 32'd0, 1'b0));
        tbl.push_back(mk(3'b000, 4'd0, 4'd0, 4'd0, 3'b000, 32'd0,   1'b0, 4'd0, 32'd0, 1'b0));

        for (int t = 0; t < tbl.size(); t++) begin
            for (int i = 0; i < NUM_SRC; i++)
                set_src(i, tbl[t].valid[i], tbl[t].robs[4*i +: 4], tbl[t].res + 32'(i), tbl[t].ls1[i]);
            step($sformatf("vec%0d.model", t));
            chk_out($sformatf("vec%0d", t), tbl[t].ev, tbl[t].epkt, 3'b111);
        end

        // Backpressure: source 2 offers 4, 6, 7 and holds each until accepted.
        bp_tags   = '{4'd4, 4'd6, 4'd7};
        bp_i      = 0;
        saw_stall = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (c < 20) begin
                set_src(0, 1'b1, 4'd8 + 4'(c % 2), 32'(c), 1'b0);
                set_src(1, 1'b1, 4'd10 + 4'(c % 2), 32'(c), 1'b0);
            end else begin
                set_src(0, 1'b0, 4'd0, 32'd0, 1'b0);
                set_src(1, 1'b0, 4'd0, 32'd0, 1'b0);
            end
            if (bp_i < 3) set_src(2, 1'b1, bp_tags[bp_i], 32'h7000 + 32'(bp_i), 1'b0);
            else          set_src(2, 1'b0, 4'd0, 32'd0, 1'b0);
            step($sformatf("bp%0d", c));
            if (last_acc[2] && bp_i < 3) bp_i++;
            if (!bus.src_ready[2]) saw_stall = 1'b1;
            if (bus.cdb_valid && (bus.cdb_out.dest_ROB_entry inside {4'd4, 4'd6, 4'd7}))
                got.push_back(bus.cdb_out.dest_ROB_entry);
        end
        idle_all();
        chk("bp.stall_seen", 64'(saw_stall), 64'd1);
        chk("bp.count", 64'(got.size()), 64'd3);
        if (got.size() == 3) begin
            chk("bp.tag0", 64'(got[0]), 64'd4);
            chk("bp.tag1", 64'(got[1]), 64'd6);
            chk("bp.tag2", 64'(got[2]), 64'd7);
        end

        // Flush with full buffers and a push presented in the flush cycle.
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NUM_SRC; i++) set_src(i, 1'b1, 4'(1 + i), 32'(c), 1'(i == 1));
            step($sformatf("fill%0d", c));
        end
        flush = 1'b1;
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 1'b1, 4'(13 + i), 32'hF00D, 1'b0);
        step("flush");
        flush = 1'b0;
        idle_all();
        chk_out("flush.after", 1'b0, '0, 3'b111);
        for (int c = 0; c < 4; c++) begin
            step($sformatf("postflush%0d", c));
            chk($sformatf("postflush%0d.quiet", c), 64'(bus.cdb_valid), 64'd0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_SRC; i++)
                set_src(i, 1'($urandom_range(0, 9) < 7), 4'($urandom_range(0, 15)),
                        $urandom, 1'($urandom_range(0, 1)));
            flush = ($urandom_range(0, 29) == 0);
            step($sformatf("rnd%0d", c));
        end
        flush = 1'b0;
        idle_all();
        repeat (4) step("drain");

        // Asynchronous reset while a packet is on the bus.
        set_src(0, 1'b1, 4'd5, 32'h1234_5678, 1'b0);
        step("pre_rst0");
        idle_all();
        set_src(1, 1'b1, 4'd6, 32'h55, 1'b0);
        step("pre_rst1");
        idle_all();
        chk("pre_rst.valid", 64'(bus.cdb_valid), 64'd1);
        #3;
        reset = 1'b1;
        #1;
        chk_out("async_rst", 1'b0, '0, 3'b111);
        m_reset();
        @(negedge clk);
        reset = 1'b0;
        step("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
